// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the instruction memory it fills.
package program_loader_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN    = 3'd1,
    S_BYTE0  = 3'd2,
    S_BYTE1  = 3'd3,
    S_WRITE  = 3'd4,
    S_FINISH = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs two consecutive stream bytes into one instruction word; the completed
// word only changes when the second byte lands, so it holds between writes.
module word_assembler
  import program_loader_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load_first,
  input  logic               load_second,
  input  logic [BYTE_W-1:0]  in_byte,
  output logic [INSTR_W-1:0] word
);

  logic [BYTE_W-1:0]  first_q;
  logic [INSTR_W-1:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= '0;
      word_q  <= '0;
    end else if (clear) begin
      first_q <= '0;
    end else if (load_first) begin
      first_q <= in_byte;
    end else if (load_second) begin
      word_q <= MSB_FIRST ? {first_q, in_byte} : {in_byte, first_q};
    end
  end

  assign word = word_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then asks the
// memory to clear everything from the first unwritten address upward.
module program_loader
  import program_loader_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BYTE_W-1:0]  in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               we,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               finish,
  output logic [ADDR_W-1:0]  clr_addr,
  output logic               busy,
  output logic               done,
  output state_t             state_dbg
);

  // in_valid/in_ready: a byte transfers on a rising edge where both are high;
  // in_ready depends only on state and abort, never on in_valid.

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, len_q, cnt_inc;
  logic              in_load, abort_load, accept;

  assign in_load    = (state_q == S_LEN) || (state_q == S_BYTE0) || (state_q == S_BYTE1);
  assign abort_load = in_load && abort;
  assign accept     = in_valid && in_ready;
  assign cnt_inc    = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LEN;
      S_LEN: begin
        if (abort)       state_d = S_FINISH;
        else if (accept) state_d = (in_byte == '0) ? S_FINISH : S_BYTE0;
      end
      S_BYTE0: begin
        if (abort)       state_d = S_FINISH;
        else if (accept) state_d = S_BYTE1;
      end
      S_BYTE1: begin
        if (abort)       state_d = S_FINISH;
        else if (accept) state_d = S_WRITE;
      end
      // An abort here still lets the current write complete.
      S_WRITE:  state_d = (abort || (cnt_inc == len_q)) ? S_FINISH : S_BYTE0;
      S_FINISH: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = in_load && !abort;
    we        = (state_q == S_WRITE);
    finish    = (state_q == S_FINISH);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      len_q    <= '0;
      wr_addr  <= '0;
      clr_addr <= '0;
    end else begin
      if (state_q == S_IDLE && start) cnt_q <= '0;
      if (state_q == S_LEN && accept) begin
        len_q <= in_byte;
        cnt_q <= '0;
      end
      if (state_q == S_WRITE) cnt_q <= cnt_inc;
      if (state_q == S_BYTE1 && accept) wr_addr <= cnt_q;
      // Leaving WRITE, cnt has not yet caught up with the write just done.
      if (state_d == S_FINISH && state_q != S_FINISH)
        clr_addr <= (state_q == S_WRITE) ? cnt_inc : cnt_q;
    end
  end

  word_assembler #(.MSB_FIRST(MSB_FIRST)) u_word_assembler (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       ((state_q == S_IDLE && start) || abort_load),
    .load_first  (state_q == S_BYTE0 && accept),
    .load_second (state_q == S_BYTE1 && accept),
    .in_byte     (in_byte),
    .word        (wr_data)
  );

endmodule
